// File: rtl/crc_pkg.sv
// Shared definitions for the CRC arbiter slice.
//   crc_arb_state_t : sequencer state encoding
//   CRC_W           : data / remainder width (fixed at 16)
//   CRC_PHASE_LEN   : cycles per shift phase
//   CRC_POLY        : CCITT polynomial implemented by the serial engine
package crc_pkg;

    localparam int CRC_W         = 16;
    localparam int CRC_PHASE_LEN = 16;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShiftData,
        StShiftZero,
        StReadOut,
        StDeliver
    } crc_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of req at or after ptr, wrapping.
//   req       : request vector
//   ptr       : index with highest priority this round
//   grant     : one-hot winner (zero when req is zero)
//   grant_idx : binary index of the winner (zero when req is zero)
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        // Upper segment [ptr, N_REQ-1] first, then wrap to [0, ptr-1].
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/crc_arbiter.sv
// Shares one serial CRC-16 engine among N_REQ requesters. Each transaction
// clears the engine, shifts 16 data bits plus 16 augmenting zeros in, reads
// the remainder back serially and returns it with a one-cycle DONE pulse.
//   CLK, RESET          : clock, synchronous active-high reset
//   REQ, REQ_DATA       : request levels and packed 16-bit words
//   GNT, DONE           : one-hot grant, one-cycle completion pulse
//   RESULT, RESULT_VALID: last remainder, valid strobe aligned with DONE
//   BUSY                : high whenever not idle
//   CRC_CLR, DATA_IN,
//   READ_MODE, CRC_OUT  : serial engine control / data
module crc_arbiter #(
    parameter int N_REQ = 4,
    parameter int CRC_W = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*CRC_W-1:0] REQ_DATA,
    output logic [N_REQ-1:0]       GNT,
    output logic [N_REQ-1:0]       DONE,
    output logic [CRC_W-1:0]       RESULT,
    output logic                   RESULT_VALID,
    output logic                   BUSY,
    output logic                   CRC_CLR,
    output logic                   DATA_IN,
    output logic                   READ_MODE,
    input  logic                   CRC_OUT
);

    import crc_pkg::*;

    localparam int IDX_W = $clog2(N_REQ);

    crc_arb_state_t   state_q;
    logic [CRC_W-1:0] data_q;
    logic [CRC_W-1:0] cap_q;
    logic [3:0]       cnt_q;
    logic [IDX_W-1:0] ptr_q;

    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] ptr_next;
    logic [CRC_W-1:0] sel_data;
    logic             last_bit;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (REQ),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_data = REQ_DATA[i*CRC_W +: CRC_W];
            end
        end
    end

    assign ptr_next = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign last_bit = (cnt_q == 4'(CRC_PHASE_LEN - 1));

    // Engine controls are registered one state ahead so that they are valid
    // for the whole cycle of the state they belong to.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= StIdle;
            data_q       <= '0;
            cap_q        <= '0;
            cnt_q        <= '0;
            ptr_q        <= '0;
            GNT          <= '0;
            DONE         <= '0;
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
            BUSY         <= 1'b0;
            CRC_CLR      <= 1'b0;
            DATA_IN      <= 1'b0;
            READ_MODE    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|REQ) begin
                        GNT     <= grant;
                        BUSY    <= 1'b1;
                        data_q  <= sel_data;
                        ptr_q   <= ptr_next;
                        CRC_CLR <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    CRC_CLR <= 1'b0;
                    DATA_IN <= data_q[CRC_W-1];
                    data_q  <= data_q << 1;
                    cnt_q   <= '0;
                    state_q <= StShiftData;
                end
                StShiftData: begin
                    if (last_bit) begin
                        DATA_IN <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StShiftZero;
                    end else begin
                        DATA_IN <= data_q[CRC_W-1];
                        data_q  <= data_q << 1;
                        cnt_q   <= cnt_q + 4'd1;
                    end
                end
                StShiftZero: begin
                    if (last_bit) begin
                        READ_MODE <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= StReadOut;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StReadOut: begin
                    cap_q <= {cap_q[CRC_W-2:0], CRC_OUT};
                    if (last_bit) begin
                        READ_MODE    <= 1'b0;
                        RESULT       <= {cap_q[CRC_W-2:0], CRC_OUT};
                        RESULT_VALID <= 1'b1;
                        DONE         <= GNT;
                        cnt_q        <= '0;
                        state_q      <= StDeliver;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StDeliver: begin
                    DONE         <= '0;
                    RESULT_VALID <= 1'b0;
                    GNT          <= '0;
                    BUSY         <= 1'b0;
                    state_q      <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/crc_arbiter.md
# crc_arbiter

Round-robin arbiter and sequencer that shares one serial CRC-16 engine among `N_REQ` requesters. It latches the winning requester's 16-bit word and clears the engine. It then drives 16 data bits and 16 augmenting zeros into the engine, reads the 16-bit remainder back serially, and returns it to the winner with a one-cycle completion pulse. It sits between the client blocks and the single serial CRC datapath, and is that datapath's only driver.

## Interface
- `N_REQ`, 4: number of requesters, 2–8.
- `CRC_W`, 16: data and CRC width. Fixed at 16; any other value is illegal.
- `CLK`  in  1  clock, rising edge.
- `RESET`  in  1  reset, synchronous, active-high; clock `CLK`.
- `REQ`  in  N_REQ  per-requester request level. Held high until the matching `DONE`.
- `REQ_DATA`  in  N_REQ*16  packed words; requester i occupies bits [16i+15:16i].
- `GNT`  out  N_REQ  one-hot grant; all zeros when idle.
- `DONE`  out  N_REQ  one-cycle completion pulse to the granted requester.
- `RESULT`  out  16  last computed CRC; held until the next completion.
- `RESULT_VALID`  out  1  high in the same cycle as any `DONE` bit.
- `BUSY`  out  1  high in every state except IDLE.
- `CRC_CLR`  out  1  one-cycle engine clear (engine register set to 0).
- `DATA_IN`  out  1  serial bit into the engine, MSB first.
- `READ_MODE`  out  1  0 = engine shifts `DATA_IN` in; 1 = engine shifts its register out on `CRC_OUT`.
- `CRC_OUT`  in  1  engine output bit, MSB first, valid in the same cycle as `READ_MODE`=1.

## Operation
- States: IDLE, LOAD, SHIFT_DATA, SHIFT_ZERO, READ_OUT, DELIVER.
- **IDLE**
  - If `REQ` is nonzero, the round-robin winner is chosen: the first set bit at or after `ptr`, wrapping.
  - At the edge: `GNT` gets one-hot(winner), the data register gets `REQ_DATA[winner]`, `ptr` gets (winner+1) mod N_REQ, and the state moves to LOAD.
- **LOAD** (1 cycle): `CRC_CLR`=1.
- **SHIFT_DATA** (16 cycles): `DATA_IN` = data[15], and data shifts left by one each cycle.
- **SHIFT_ZERO** (16 cycles): `DATA_IN`=0.
- **READ_OUT** (16 cycles)
  - `READ_MODE`=1.
  - The capture register gets {cap[14:0], `CRC_OUT`} each cycle.
- **DELIVER** (1 cycle)
  - `RESULT` gets the capture value; `RESULT_VALID`=1 and `DONE[winner]`=1 are registered into this cycle.
  - `GNT` clears at the end of the cycle; next state is IDLE.
- A single 4-bit bit counter serves all three shift phases. It counts 0–15 and resets to 0 on every phase change.
- `REQ` dropping mid-transaction is ignored: the transaction completes and `DONE` still pulses.
- `REQ` changes on non-granted lines during a transaction have no effect until IDLE.
- `REQ_DATA` is sampled only at the IDLE→LOAD edge.
- In every state except those listed above, `DATA_IN`=0, `READ_MODE`=0 and `CRC_CLR`=0.
- Reset, including reset mid-transaction:
  - State IDLE, `ptr`=0, counters 0.
  - `GNT`, `DONE`, `RESULT`, `RESULT_VALID`, `BUSY`, `CRC_CLR`, `DATA_IN`, `READ_MODE` all 0.
  - No `DONE` is issued for an aborted transaction.

## Timing
- Request sampled high in IDLE at edge t0:
  - `GNT`/`BUSY` rise after t0.
  - `CRC_CLR` is high in the cycle after t0.
  - SHIFT_DATA runs in the cycles after t0+1 through t0+16.
  - SHIFT_ZERO runs in the cycles after t0+17 through t0+32.
  - READ_OUT runs in the cycles after t0+33 through t0+48.
  - `DONE`/`RESULT_VALID` are high in the cycle after t0+49.
  - `GNT`/`BUSY` fall after t0+50.
- Service time is 51 cycles per request, including the mandatory IDLE cycle. The next grant can occur at edge t0+51.
- A requester that deasserts `REQ` on the edge ending its `DONE` cycle is not re-granted.

## Structure
- Package `crc_pkg`:
  - state enum `crc_arb_state_t` (typedef logic [2:0]);
  - `CRC_W`=16;
  - `CRC_PHASE_LEN`=16;
  - `CRC_POLY`=16'h1021, used by the bench model.
- Sub-module `rr_arbiter`:
  - parameter `N_REQ`;
  - combinational inputs `req`, `ptr`;
  - outputs one-hot `grant` and binary `grant_idx`.
- The `crc_arbiter` top holds the state machine, data/capture shift registers, bit counter and `ptr`.

## Test plan
- Bench CRC model: serial LFSR, poly 0x1021, cleared by `CRC_CLR`, shifts in while `READ_MODE`=0, shifts MSB out while `READ_MODE`=1.
- Single request: `REQ`=0001, data 0x0001 → `GNT`=0001 after t0; `DONE`=0001 and `RESULT`=0x1021 in the cycle after t0+49.
- Data 0x0002 → 0x2042. Data 0x0000 → 0x0000. Back-to-back on requester 2 → `DONE` pulses 51 cycles apart.
- All four requesting continuously, with data 0x0001, 0x0002, 0x0000, 0x0001:
  - grant order 0,1,2,3,0;
  - results 0x1021, 0x2042, 0x0000, 0x1021.
- Fairness wrap: `ptr`=3 and `REQ`=1001 → requester 3 is granted first, then requester 0.
- Requester 1 drops `REQ` during SHIFT_ZERO → transaction completes, `DONE`=0010 and the `RESULT` value is correct.
- `RESET` asserted during READ_OUT:
  - all outputs are 0 on the next cycle and no `DONE` is issued;
  - with `REQ`=0110 afterwards, requester 1 is granted first (`ptr`=0).
